snes_pad_poller: RTL and testbench
==================================

Name: snes_pad_poller

Overview:
- Upstream stage of the joypad register block: drives the SNES-style serial pad interface (latch, clock, data) from the system clock.
- Periodically shifts in 16 button bits, then debounces and inverts them.
- Presents a stable, active-high 16-bit button vector to the joypad register logic, with one-cycle valid and changed strobes.
- Replaces free-running capture on the pad clock with fully synchronous capture in the `clock` domain.

Parameters:
- CLK_DIV, 4: length of each pad_clk phase in system clocks. Half-period D. Must be >= 4.
- LATCH_CYCLES, 8: pad_latch high width in system clocks.
- POLL_PERIOD, 200: system clocks between scan starts. Must be > LATCH_CYCLES + 31*CLK_DIV + 2.
- DEBOUNCE_POLLS, 2: consecutive identical frames required before the button vector updates. Must be >= 1.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pad_data  in  1  serial data from pad; active-low, 0 = pressed; asynchronous to clock.
- pad_latch  out  1  latch pulse to pad; registered.
- pad_clk  out  1  shift clock to pad; idles high; registered.
- buttons  out  16  debounced button state, 1 = pressed. Bit order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12-15 unused.
- buttons_valid  out  1  one-cycle pulse after every completed scan.
- buttons_changed  out  1  one-cycle pulse, coincident with buttons_valid, when buttons took a new value.
- busy  out  1  high while a scan is in progress (any state other than IDLE).

Behaviour:
- Reset (async, while reset_n = 0):
  - pad_latch = 0, pad_clk = 1, buttons = 0, buttons_valid = 0, buttons_changed = 0, busy = 0.
  - FSM = IDLE; poll counter = 0; synchronizer = 2'b11; shift register = 0; last_raw = 0; match_cnt = 0.
- pad_data passes through a 2-FF synchronizer. Every "sample" below uses the synchronizer output.
- Poll counter:
  - Free-running, 0..POLL_PERIOD-1, then wraps to 0.
  - Tick = counter at POLL_PERIOD-1.
  - A tick in IDLE starts a scan on the next cycle. A tick while busy is ignored; it cannot occur under the parameter constraint.
- FSM states and timing:
  - IDLE: pad_latch = 0, pad_clk = 1. Goes to LATCH on tick.
  - LATCH: pad_latch = 1 for LATCH_CYCLES cycles. Goes to BIT0.
  - BIT0: pad_latch = 0, pad_clk = 1 for CLK_DIV cycles. Bit 0 is sampled on the last cycle. Goes to CLK_LO with bit index = 1.
  - CLK_LO: pad_clk = 0 for CLK_DIV cycles. Goes to CLK_HI.
  - CLK_HI: pad_clk = 1 for CLK_DIV cycles. Bit[index] is sampled on the last cycle. If index = 15, go to DONE; otherwise increment index and go to CLK_LO.
  - DONE: 1 cycle. Runs the debounce update. Goes to IDLE.
- Scan length = LATCH_CYCLES + CLK_DIV + 30*CLK_DIV + 1 cycles; 133 at defaults. pad_clk produces exactly 15 low pulses per scan.
- Raw frame: raw = ~shift (inverted so that 1 = pressed).
- Debounce, in DONE:
  - If raw == last_raw, match_cnt <= min(match_cnt+1, DEBOUNCE_POLLS); otherwise match_cnt <= 1.
  - last_raw <= raw in either case.
  - If the new match_cnt == DEBOUNCE_POLLS and raw != buttons, then buttons <= raw.
- Strobes:
  - buttons_valid = 1 on the cycle after DONE, the same cycle buttons shows its updated value.
  - buttons_changed = 1 on that same cycle only if buttons changed.
  - Both strobes are 0 on every other cycle.
- buttons is written only in DONE; it holds its value otherwise.
- Disconnected pad (data pulled high): raw = 0, so buttons decays to 0 through the normal debounce.
- Reset mid-scan: immediate return to the reset state. pad_latch drops and pad_clk goes high asynchronously; no partial frame is ever committed.

Test Plan (defaults unless stated; pad model shifts on the pad_clk rising edge and presents bit 0 when pad_latch falls):
1. Release reset and hold pad_data = 1 -> first pad_latch rise occurs POLL_PERIOD cycles after release. Latch is high for 8 cycles. 15 pad_clk low pulses of 4 cycles each follow. busy is high for 133 cycles. buttons_valid pulses once, buttons stays 16'h0000, buttons_changed stays 0.
2. Pad reports A and Start pressed (bits 8 and 3 low) -> scan 1: buttons = 0, valid pulse only. Scan 2: buttons = 16'h0108 with valid and changed pulsing together. Scan 3: valid only.
3. Frames alternate 16'h0010 / 16'h0000 for 6 scans -> buttons stays 16'h0000; buttons_changed never pulses.
4. Assert reset_n = 0 during bit 7 of a scan in which Right is held -> pad_latch = 0 and pad_clk = 1 immediately. After release, the next scan starts POLL_PERIOD cycles later and buttons reaches 16'h0080 only after 2 full scans.
5. DEBOUNCE_POLLS = 1, Up pressed -> buttons = 16'h0010 after the first scan, with changed pulsing. Releasing Up gives buttons = 16'h0000 after the next scan.
6. CLK_DIV = 6, LATCH_CYCLES = 12, POLL_PERIOD = 400 -> scan length is 12 + 6 + 180 + 1 = 199 cycles. Every pad_clk phase is 6 cycles. Walking a single pressed bit across positions 0..11 maps each to buttons bit 0..11 in turn.

Source files
------------

// File: rtl/snes_pad_poller.sv
// SNES-style pad poller: periodically latches the pad, shifts in 16 bits
// synchronously to `clock`, then debounces and inverts them into an
// active-high button vector with one-cycle valid/changed strobes.
module snes_pad_poller #(
   parameter int unsigned CLK_DIV        = 4,
   parameter int unsigned LATCH_CYCLES   = 8,
   parameter int unsigned POLL_PERIOD    = 200,
   parameter int unsigned DEBOUNCE_POLLS = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        pad_data,
   output logic        pad_latch,
   output logic        pad_clk,
   output logic [15:0] buttons,
   output logic        buttons_valid,
   output logic        buttons_changed,
   output logic        busy
);

   localparam int unsigned CNT_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int unsigned PH_MAX = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
   localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
   localparam int unsigned MC_W   = $clog2(DEBOUNCE_POLLS + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);
   localparam logic [PH_W-1:0]  LAT_LAST = PH_W'(LATCH_CYCLES - 1);
   localparam logic [PH_W-1:0]  DIV_LAST = PH_W'(CLK_DIV - 1);
   localparam logic [MC_W-1:0]  MC_FULL  = MC_W'(DEBOUNCE_POLLS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_BIT0,
      S_CLK_LO,
      S_CLK_HI,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   logic [3:0]        idx_q, idx_d;
   logic [15:0]       shift_q, shift_d;
   logic [1:0]        sync_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [15:0]       last_raw_q, last_raw_d;
   logic [MC_W-1:0]   match_q, match_d;
   logic [MC_W-1:0]   match_nxt;
   logic [15:0]       buttons_q, buttons_d;
   logic              valid_q, valid_d;
   logic              changed_q, changed_d;
   logic              latch_q, latch_d;
   logic              pclk_q, pclk_d;

   logic              data_s;
   logic              tick;
   logic [15:0]       raw;

   assign data_s = sync_q[1];
   assign tick   = (cnt_q == CNT_LAST);
   assign raw    = ~shift_q;

   // Two-flop synchronizer for the asynchronous pad data line (idles high).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], pad_data};
      end
   end

   // Free-running poll period counter; its terminal count is the scan tick.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Scan sequencing, bit capture and debounce decision for the next cycle.
   always_comb begin
      state_d    = state_q;
      ph_d       = ph_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      last_raw_d = last_raw_q;
      match_d    = match_q;
      match_nxt  = match_q;
      buttons_d  = buttons_q;
      valid_d    = 1'b0;
      changed_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            ph_d = '0;
            if (tick) begin
               state_d = S_LATCH;
            end
         end

         S_LATCH: begin
            if (ph_q == LAT_LAST) begin
               ph_d    = '0;
               state_d = S_BIT0;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end

         S_BIT0: begin
            if (ph_q == DIV_LAST) begin
               shift_d[0] = data_s;
               ph_d       = '0;
               idx_d      = 4'd1;
               state_d    = S_CLK_LO;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end

         S_CLK_LO: begin
            if (ph_q == DIV_LAST) begin
               ph_d    = '0;
               state_d = S_CLK_HI;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end

         S_CLK_HI: begin
            if (ph_q == DIV_LAST) begin
               shift_d[idx_q] = data_s;
               ph_d           = '0;
               if (idx_q == 4'd15) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_CLK_LO;
               end
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end

         S_DONE: begin
            if (raw == last_raw_q) begin
               match_nxt = (match_q == MC_FULL) ? match_q : match_q + 1'b1;
            end else begin
               match_nxt = MC_W'(1);
            end
            match_d    = match_nxt;
            last_raw_d = raw;
            valid_d    = 1'b1;
            if ((match_nxt == MC_FULL) && (raw != buttons_q)) begin
               buttons_d = raw;
               changed_d = 1'b1;
            end
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Pad pins are registered from the next state so they line up with it.
      latch_d = (state_d == S_LATCH);
      pclk_d  = (state_d != S_CLK_LO);
   end

   // State, datapath and registered pad/strobe outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         ph_q       <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         last_raw_q <= '0;
         match_q    <= '0;
         buttons_q  <= '0;
         valid_q    <= 1'b0;
         changed_q  <= 1'b0;
         latch_q    <= 1'b0;
         pclk_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         last_raw_q <= last_raw_d;
         match_q    <= match_d;
         buttons_q  <= buttons_d;
         valid_q    <= valid_d;
         changed_q  <= changed_d;
         latch_q    <= latch_d;
         pclk_q     <= pclk_d;
      end
   end

   assign pad_latch       = latch_q;
   assign pad_clk         = pclk_q;
   assign buttons         = buttons_q;
   assign buttons_valid   = valid_q;
   assign buttons_changed = changed_q;
   assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_snes_pad_poller.sv
// Bench for snes_pad_poller: three parameterisations driven by behavioural
// pad models; a scoreboard queue holds expected per-scan results.
module tb_snes_pad_poller;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] frame = '0;   // pressed buttons, 1 = pressed
   int          sel   = 0;
   int          n_vec = 0;
   int          n_err = 0;
   int          scans = 0;

   typedef struct {
      string       tag;
      logic [15:0] btn;
      logic        chg;
   } exp_t;
   exp_t exp_q[$];
   exp_t e_mon;

   always #5 clock = ~clock;

   logic pd_a = 1'b1, pd_b = 1'b1, pd_c = 1'b1;
   logic pad_latch_a, pad_clk_a, valid_a, chg_a, busy_a;
   logic pad_latch_b, pad_clk_b, valid_b, chg_b, busy_b;
   logic pad_latch_c, pad_clk_c, valid_c, chg_c, busy_c;
   logic [15:0] btn_a, btn_b, btn_c;

   snes_pad_poller dut_a (
      .clock(clock), .reset_n(rst_n), .pad_data(pd_a),
      .pad_latch(pad_latch_a), .pad_clk(pad_clk_a), .buttons(btn_a),
      .buttons_valid(valid_a), .buttons_changed(chg_a), .busy(busy_a));

   snes_pad_poller #(.DEBOUNCE_POLLS(1)) dut_b (
      .clock(clock), .reset_n(rst_n), .pad_data(pd_b),
      .pad_latch(pad_latch_b), .pad_clk(pad_clk_b), .buttons(btn_b),
      .buttons_valid(valid_b), .buttons_changed(chg_b), .busy(busy_b));

   snes_pad_poller #(.CLK_DIV(6), .LATCH_CYCLES(12), .POLL_PERIOD(400)) dut_c (
      .clock(clock), .reset_n(rst_n), .pad_data(pd_c),
      .pad_latch(pad_latch_c), .pad_clk(pad_clk_c), .buttons(btn_c),
      .buttons_valid(valid_c), .buttons_changed(chg_c), .busy(busy_c));

   // Pad models: load on latch fall (bit 0 out), shift on pad_clk rise.
   logic [15:0] sr_a = '1, sr_b = '1, sr_c = '1;
   logic pl_a = 1'b0, pc_a = 1'b1, pl_b = 1'b0, pc_b = 1'b1, pl_c = 1'b0, pc_c = 1'b1;

   always @(pad_latch_a, pad_clk_a) begin
      if (pl_a && !pad_latch_a) sr_a = ~frame;
      else if (!pc_a && pad_clk_a) sr_a = {1'b1, sr_a[15:1]};
      pl_a = pad_latch_a; pc_a = pad_clk_a; pd_a = sr_a[0];
   end
   always @(pad_latch_b, pad_clk_b) begin
      if (pl_b && !pad_latch_b) sr_b = ~frame;
      else if (!pc_b && pad_clk_b) sr_b = {1'b1, sr_b[15:1]};
      pl_b = pad_latch_b; pc_b = pad_clk_b; pd_b = sr_b[0];
   end
   always @(pad_latch_c, pad_clk_c) begin
      if (pl_c && !pad_latch_c) sr_c = ~frame;
      else if (!pc_c && pad_clk_c) sr_c = {1'b1, sr_c[15:1]};
      pl_c = pad_latch_c; pc_c = pad_clk_c; pd_c = sr_c[0];
   end

   // Observed signals of the instance under test.
   logic latch_s, clk_s, valid_s, chg_s, busy_s;
   logic [15:0] btn_s;
   always_comb begin
      latch_s = pad_latch_a; clk_s = pad_clk_a; valid_s = valid_a;
      chg_s = chg_a; busy_s = busy_a; btn_s = btn_a;
      case (sel)
         1: begin
            latch_s = pad_latch_b; clk_s = pad_clk_b; valid_s = valid_b;
            chg_s = chg_b; busy_s = busy_b; btn_s = btn_b;
         end
         2: begin
            latch_s = pad_latch_c; clk_s = pad_clk_c; valid_s = valid_c;
            chg_s = chg_c; busy_s = busy_c; btn_s = btn_c;
         end
         default: ;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [15:0] btn, input logic chg);
      exp_t e;
      e.tag = tag; e.btn = btn; e.chg = chg;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every valid pulse consumes one expected scan result.
   always @(negedge clock) begin
      if (rst_n && valid_s) begin
         scans++;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", {16'd0, btn_s}, 32'hFFFF_FFFF);
         end else begin
            e_mon = exp_q.pop_front();
            check({e_mon.tag, "_buttons"}, {16'd0, btn_s}, {16'd0, e_mon.btn});
            check({e_mon.tag, "_changed"}, {31'd0, chg_s}, {31'd0, e_mon.chg});
         end
      end
      if (rst_n && chg_s && !valid_s) begin
         check("changed_without_valid", {31'd0, chg_s}, 32'd0);
      end
   end

   task automatic wait_scans(input string tag, input int n);
      int target;
      int cyc;
      target = scans + n;
      cyc = 0;
      while (scans < target && cyc < 1000 * n) begin
         @(posedge clock);
         cyc++;
      end
      check({tag, "_scan_count"}, scans, target);
   endtask

   // Counts negedge samples until pad_latch is seen high.
   task automatic wait_latch(output int n, input int limit);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!latch_s && n < limit);
   endtask

   // Profiles one scan starting at the sample where pad_latch first rose.
   task automatic measure_scan(input string tag, input int exp_lat, input int exp_div,
                               input int exp_len);
      int lat_hi = 0, busy_n = 0, lo_tot = 0, falls = 0, lo_run = 0, lo_max = 0;
      int hi_run = 0, hi_min = 1000, hi_max = 0;
      logic pc = 1'b1;
      for (int i = 0; i < exp_len + 20; i++) begin
         if (latch_s) lat_hi++;
         if (busy_s) busy_n++;
         if (!clk_s) begin
            lo_tot++;
            lo_run++;
            if (lo_run > lo_max) lo_max = lo_run;
            if (pc) begin
               falls++;
               if (hi_run < hi_min) hi_min = hi_run;
               if (hi_run > hi_max) hi_max = hi_run;
               hi_run = 0;
            end
         end else begin
            lo_run = 0;
            if (!latch_s && busy_s) hi_run++;
         end
         pc = clk_s;
         @(negedge clock);
      end
      check({tag, "_latch_width"}, lat_hi, exp_lat);
      check({tag, "_busy_len"}, busy_n, exp_len);
      check({tag, "_clk_falls"}, falls, 15);
      check({tag, "_clk_low_total"}, lo_tot, 15 * exp_div);
      check({tag, "_clk_low_max"}, lo_max, exp_div);
      check({tag, "_clk_high_min"}, hi_min, exp_div);
      check({tag, "_clk_high_max"}, hi_max, exp_div);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int s0;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_latch", latch_s, 0);
      check("rst_clk", clk_s, 1);
      check("rst_busy", busy_s, 0);
      check("rst_buttons", btn_s, 0);
      check("rst_valid", valid_s, 0);
      check("rst_changed", chg_s, 0);

      // 1: idle pad, scan timing profile
      push("t1", 16'h0000, 1'b0);
      s0 = scans;
      @(negedge clock);
      rst_n = 1'b1;
      wait_latch(n, 1000);
      check("t1_first_latch", n, 200);
      measure_scan("t1", 8, 4, 133);
      check("t1_valid_pulses", scans - s0, 1);
      check("t1_queue_empty", exp_q.size(), 0);

      // 2: A + Start pressed
      frame = 16'h0108;
      push("t2_s1", 16'h0000, 1'b0);
      push("t2_s2", 16'h0108, 1'b1);
      push("t2_s3", 16'h0108, 1'b0);
      wait_scans("t2", 3);

      // 3: alternating frames never settle
      @(negedge clock);
      rst_n = 1'b0;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         frame = (i % 2 == 0) ? 16'h0010 : 16'h0000;
         push("t3", 16'h0000, 1'b0);
         wait_scans("t3", 1);
      end

      // 4: reset during bit 7 with Right held
      frame = 16'h0080;
      wait_latch(n, 1000);
      check("t4_latch_seen", latch_s, 1);
      repeat (62) @(negedge clock);
      check("t4_pre_clk_low", clk_s, 0);
      check("t4_pre_busy", busy_s, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t4_rst_latch", latch_s, 0);
      check("t4_rst_clk", clk_s, 1);
      check("t4_rst_busy", busy_s, 0);
      check("t4_rst_buttons", btn_s, 0);
      @(negedge clock);
      rst_n = 1'b1;
      push("t4_s1", 16'h0000, 1'b0);
      push("t4_s2", 16'h0080, 1'b1);
      wait_latch(n, 1000);
      check("t4_restart_latch", n, 200);
      wait_scans("t4", 2);

      // 5: DEBOUNCE_POLLS = 1
      @(negedge clock);
      rst_n = 1'b0;
      sel = 1;
      frame = 16'h0010;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      push("t5_press", 16'h0010, 1'b1);
      wait_scans("t5a", 1);
      frame = 16'h0000;
      push("t5_release", 16'h0000, 1'b1);
      wait_scans("t5b", 1);
      push("t5_hold", 16'h0000, 1'b0);
      wait_scans("t5c", 1);

      // 6: CLK_DIV = 6, LATCH_CYCLES = 12, POLL_PERIOD = 400, walking bit
      @(negedge clock);
      rst_n = 1'b0;
      sel = 2;
      frame = 16'h0001;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      push("t6_b0_s1", 16'h0000, 1'b0);
      wait_latch(n, 1000);
      check("t6_first_latch", n, 400);
      measure_scan("t6", 12, 6, 199);
      push("t6_b0_s2", 16'h0001, 1'b1);
      wait_scans("t6_b0", 1);
      for (int i = 1; i < 12; i++) begin
         frame = 16'(1) << i;
         push($sformatf("t6_b%0d_s1", i), 16'(1) << (i - 1), 1'b0);
         push($sformatf("t6_b%0d_s2", i), 16'(1) << i, 1'b1);
         wait_scans($sformatf("t6_b%0d", i), 2);
      end
      check("t6_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
